// File: rtl/regfile_pkg.sv
// Shared constants and pure helpers for the register bank.
package regfile_pkg;

  localparam int unsigned DefWidth    = 16;
  localparam int unsigned DefNregs    = 14;
  localparam int unsigned DefNleft    = 2;
  localparam int unsigned DefPairBase = 6;
  localparam int unsigned DefNpairs   = 4;

  // Helpers work on fixed maximum widths; callers cast to/from their own widths.
  localparam int unsigned MaxRegs  = 64;
  localparam int unsigned MaxPairs = 32;

  typedef logic [MaxRegs-1:0]  sel_vec_t;
  typedef logic [MaxPairs-1:0] pair_vec_t;

  // Logical-to-physical select remap: a set map bit swaps the two selects of its pair.
  function automatic sel_vec_t remap_sel(input sel_vec_t sel, input pair_vec_t map,
                                         input int unsigned pair_base,
                                         input int unsigned npairs);
    sel_vec_t res;
    res = sel;
    for (int unsigned i = 0; i < MaxRegs; i++) begin
      if (i >= pair_base && i < pair_base + 2 * npairs) begin
        if (map[(i - pair_base) / 2]) begin
          res[i] = sel[pair_base + ((i - pair_base) ^ 32'd1)];
        end
      end
    end
    return res;
  endfunction

  // Mask with bits lo..hi-1 set.
  function automatic sel_vec_t seg_mask(input int unsigned lo, input int unsigned hi);
    sel_vec_t res;
    for (int unsigned i = 0; i < MaxRegs; i++) begin
      res[i] = (i >= lo) && (i < hi);
    end
    return res;
  endfunction

  // True when two or more bits are set.
  function automatic logic multi_hot(input sel_vec_t v);
    return (v & (v - sel_vec_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/regfile_swap_map.sv
// Exchange-mapping flops (EX/EXX style) and the logical-to-physical select remap.
module regfile_swap_map
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS     = DefNregs,
  parameter int unsigned PAIR_BASE = DefPairBase,
  parameter int unsigned NPAIRS    = DefNpairs
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPAIRS-1:0] swap,
  input  logic [NREGS-1:0]  sel,
  output logic [NPAIRS-1:0] swap_map,
  output logic [NREGS-1:0]  sel_phys
);

  logic [NPAIRS-1:0] map_q, map_d;

  // Each swap pulse toggles its pair; the toggle takes effect after the edge.
  always_comb begin
    map_d = map_q ^ swap;
  end

  // Mapping state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_q <= '0;
    end else begin
      map_q <= map_d;
    end
  end

  assign swap_map = map_q;

  // Remap uses the current (pre-toggle) map.
  assign sel_phys = NREGS'(remap_sel(sel_vec_t'(sel), pair_vec_t'(map_q), PAIR_BASE, NPAIRS));

endmodule

// File: rtl/regfile_bank.sv
// Multi-bit register file on a precharged wired-AND bus that can be split
// into a left (PC) segment and a right (data) segment, or joined.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int unsigned            WIDTH     = DefWidth,
  parameter int unsigned            NREGS     = DefNregs,
  parameter int unsigned            NLEFT     = DefNleft,
  parameter int unsigned            PAIR_BASE = DefPairBase,
  parameter int unsigned            NPAIRS    = DefNpairs,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic              eclk,
  input  logic              erst,
  input  logic              r_p,
  input  logic              pc_wr,
  input  logic [WIDTH-1:0]  pc_din,
  input  logic              reg_wr,
  input  logic [WIDTH-1:0]  reg_din,
  input  logic [NREGS-1:0]  sel,
  input  logic [NPAIRS-1:0] swap,
  output logic [WIDTH-1:0]  pc_dout,
  output logic [WIDTH-1:0]  reg_dout,
  output logic [NPAIRS-1:0] swap_map,
  output logic              sel_conflict
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0] sel_phys;
  logic [NREGS-1:0] left_mask, right_mask;
  logic [WIDTH-1:0] and_left, and_right, and_all;
  logic [WIDTH-1:0] wr_val;
  logic [WIDTH-1:0] left_bus, right_bus;
  logic             ld_left, ld_right;
  logic             conflict_d;

  regfile_swap_map #(
    .NREGS     (NREGS),
    .PAIR_BASE (PAIR_BASE),
    .NPAIRS    (NPAIRS)
  ) u_swap_map (
    .clk      (eclk),
    .rst      (erst),
    .swap     (swap),
    .sel      (sel),
    .swap_map (swap_map),
    .sel_phys (sel_phys)
  );

  assign left_mask  = NREGS'(seg_mask(0, NLEFT));
  assign right_mask = ~left_mask;

  // Wired-AND of selected storage, per segment and over the whole array.
  always_comb begin
    and_left  = '1;
    and_right = '1;
    and_all   = '1;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (sel_phys[i]) begin
        and_all = and_all & regs_q[i];
        if (left_mask[i]) begin
          and_left = and_left & regs_q[i];
        end else begin
          and_right = and_right & regs_q[i];
        end
      end
    end
  end

  // Bus resolution: writers override storage; undriven bus stays precharged high.
  always_comb begin
    wr_val = '1;
    if (pc_wr) begin
      wr_val = wr_val & pc_din;
    end
    if (reg_wr) begin
      wr_val = wr_val & reg_din;
    end
    if (r_p) begin
      left_bus  = (pc_wr || reg_wr) ? wr_val : and_all;
      right_bus = left_bus;
    end else begin
      left_bus  = pc_wr ? pc_din : and_left;
      right_bus = reg_wr ? reg_din : and_right;
    end
  end

  // Load enables and the storage-driven multi-select flag.
  always_comb begin
    ld_left  = pc_wr | (r_p & reg_wr);
    ld_right = reg_wr | (r_p & pc_wr);
    if (r_p) begin
      conflict_d = !(pc_wr || reg_wr) && multi_hot(sel_vec_t'(sel_phys));
    end else begin
      conflict_d = (!pc_wr && multi_hot(sel_vec_t'(sel_phys & left_mask))) ||
                   (!reg_wr && multi_hot(sel_vec_t'(sel_phys & right_mask)));
    end
  end

  // Register storage; every selected register in a loading segment takes the bus value.
  always_ff @(posedge eclk or posedge erst) begin
    if (erst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (sel_phys[i]) begin
          if (left_mask[i]) begin
            if (ld_left) begin
              regs_q[i] <= left_bus;
            end
          end else if (ld_right) begin
            regs_q[i] <= right_bus;
          end
        end
      end
    end
  end

  // Output registers; left bus is presented inverted.
  always_ff @(posedge eclk or posedge erst) begin
    if (erst) begin
      pc_dout      <= '1;
      reg_dout     <= '0;
      sel_conflict <= 1'b0;
    end else begin
      pc_dout      <= ~left_bus;
      reg_dout     <= right_bus;
      sel_conflict <= conflict_d;
    end
  end

endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank: directed steps plus random traffic
// against a behavioural model of the register file.
module tb_regfile_bank;

  localparam int W  = 16;
  localparam int NR = 14;
  localparam int NL = 2;
  localparam int PB = 6;
  localparam int NP = 4;

  logic          eclk = 1'b0;
  logic          erst;
  logic          r_p, pc_wr, reg_wr;
  logic [W-1:0]  pc_din, reg_din;
  logic [NR-1:0] sel;
  logic [NP-1:0] swap;
  logic [W-1:0]  pc_dout, reg_dout;
  logic [NP-1:0] swap_map;
  logic          sel_conflict;

  regfile_bank dut (
    .eclk         (eclk),
    .erst         (erst),
    .r_p          (r_p),
    .pc_wr        (pc_wr),
    .pc_din       (pc_din),
    .reg_wr       (reg_wr),
    .reg_din      (reg_din),
    .sel          (sel),
    .swap         (swap),
    .pc_dout      (pc_dout),
    .reg_dout     (reg_dout),
    .swap_map     (swap_map),
    .sel_conflict (sel_conflict)
  );

  always #5 eclk = ~eclk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [W-1:0]  m_regs [NR];
  logic [NP-1:0] m_map;
  logic [W-1:0]  m_pc, m_reg;
  logic          m_conf;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int phys(input int i);
    if (i >= PB && i < PB + 2 * NP && m_map[(i - PB) / 2]) return PB + ((i - PB) ^ 1);
    return i;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_map  = '0;
    m_pc   = '1;
    m_reg  = '0;
    m_conf = 1'b0;
  endtask

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_edge();
    bit [NR-1:0]  ps;
    logic [W-1:0] lr, rr, ar, v, lb, rb;
    int           nl, nr;
    logic         conf;
    ps = '0; lr = '1; rr = '1; ar = '1; nl = 0; nr = 0;
    for (int i = 0; i < NR; i++) if (sel[i]) ps[phys(i)] = 1'b1;
    for (int j = 0; j < NR; j++) begin
      if (ps[j]) begin
        ar &= m_regs[j];
        if (j < NL) begin lr &= m_regs[j]; nl++; end
        else begin rr &= m_regs[j]; nr++; end
      end
    end
    if (r_p) begin
      if (pc_wr || reg_wr) begin
        v = '1;
        if (pc_wr) v &= pc_din;
        if (reg_wr) v &= reg_din;
      end else begin
        v = ar;
      end
      lb = v; rb = v;
      conf = !(pc_wr || reg_wr) && (nl + nr > 1);
    end else begin
      lb = pc_wr ? pc_din : lr;
      rb = reg_wr ? reg_din : rr;
      conf = (!pc_wr && nl > 1) || (!reg_wr && nr > 1);
    end
    for (int j = 0; j < NR; j++) begin
      if (ps[j]) begin
        if (j < NL && (pc_wr || (r_p && reg_wr))) m_regs[j] = lb;
        if (j >= NL && (reg_wr || (r_p && pc_wr))) m_regs[j] = rb;
      end
    end
    m_pc   = ~lb;
    m_reg  = rb;
    m_conf = conf;
    m_map  = m_map ^ swap;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "/pc_dout"}, pc_dout, m_pc);
    check({tag, "/reg_dout"}, reg_dout, m_reg);
    check({tag, "/swap_map"}, 16'(swap_map), 16'(m_map));
    check({tag, "/sel_conflict"}, 16'(sel_conflict), 16'(m_conf));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge eclk);
    #1;
    compare_model(tag);
  endtask

  task automatic drive(input logic rp, input logic pw, input logic [W-1:0] pd,
                       input logic rw, input logic [W-1:0] rd,
                       input logic [NR-1:0] s, input logic [NP-1:0] sw);
    r_p = rp; pc_wr = pw; pc_din = pd; reg_wr = rw; reg_din = rd; sel = s; swap = sw;
  endtask

  initial begin
    erst = 1'b1;
    drive(0, 0, '0, 0, '0, '0, '0);
    model_reset();
    repeat (2) @(posedge eclk);
    #1;
    check("reset/pc_dout", pc_dout, 16'hFFFF);
    check("reset/reg_dout", reg_dout, 16'h0000);
    check("reset/swap_map", 16'(swap_map), 16'h0);
    check("reset/sel_conflict", 16'(sel_conflict), 16'h0);
    erst = 1'b0;

    // Idle: precharged buses
    tick("idle");
    check("idle/pc_dout", pc_dout, 16'h0000);
    check("idle/reg_dout", reg_dout, 16'hFFFF);

    // Split write then read
    drive(0, 1, 16'h1234, 1, 16'hA5A5, 14'h0041, '0);
    tick("split_wr");
    drive(0, 0, '0, 0, '0, 14'h0041, '0);
    tick("split_rd");
    check("split_rd/pc_dout", pc_dout, 16'hEDCB);
    check("split_rd/reg_dout", reg_dout, 16'hA5A5);

    // Joined write reaches both segments
    drive(1, 1, 16'h00FF, 0, '0, 14'h0202, '0);
    tick("joined_wr");
    drive(0, 0, '0, 0, '0, 14'h0202, '0);
    tick("joined_rd");
    check("joined_rd/pc_dout", pc_dout, 16'hFF00);
    check("joined_rd/reg_dout", reg_dout, 16'h00FF);

    // Two joined writers wire-AND
    drive(1, 1, 16'hF0F0, 1, 16'h3C3C, '0, '0);
    tick("wand");
    check("wand/pc_dout", pc_dout, 16'hCFCF);
    check("wand/reg_dout", reg_dout, 16'h3030);

    // Swap pair 0
    drive(0, 0, '0, 1, 16'h1111, 14'h0040, '0);
    tick("wr6");
    drive(0, 0, '0, 1, 16'h2222, 14'h0080, '0);
    tick("wr7");
    drive(0, 0, '0, 0, '0, '0, 4'b0001);
    tick("swap1");
    drive(0, 0, '0, 0, '0, 14'h0040, '0);
    tick("rd6_swapped");
    check("rd6_swapped/reg_dout", reg_dout, 16'h2222);
    drive(0, 0, '0, 0, '0, '0, 4'b0001);
    tick("swap2");
    drive(0, 0, '0, 0, '0, 14'h0040, '0);
    tick("rd6_restored");
    check("rd6_restored/reg_dout", reg_dout, 16'h1111);

    // Write in swap cycle lands per old map (physical 6)
    drive(0, 0, '0, 1, 16'h3333, 14'h0040, 4'b0001);
    tick("swap_wr");
    drive(0, 0, '0, 0, '0, 14'h0080, '0);
    tick("rd7_after_swap_wr");
    check("rd7_after_swap_wr/reg_dout", reg_dout, 16'h3333);
    drive(0, 0, '0, 0, '0, '0, 4'b0001);
    tick("swap3");

    // Conflict in right segment
    drive(0, 0, '0, 1, 16'hFF00, 14'h0040, '0);
    tick("wr6b");
    drive(0, 0, '0, 1, 16'h0FF0, 14'h0100, '0);
    tick("wr8");
    drive(0, 0, '0, 0, '0, 14'h0140, '0);
    tick("conflict");
    check("conflict/reg_dout", reg_dout, 16'h0F00);
    check("conflict/sel_conflict", 16'(sel_conflict), 16'h1);

    // Async reset in the middle of a write
    drive(0, 0, '0, 0, '0, '0, 4'b0010);
    tick("swap_pair1");
    drive(0, 0, '0, 1, 16'hBEEF, 14'h0100, '0);
    #2 erst = 1'b1;
    #1;
    check("async_rst/pc_dout", pc_dout, 16'hFFFF);
    check("async_rst/reg_dout", reg_dout, 16'h0000);
    check("async_rst/swap_map", 16'(swap_map), 16'h0);
    check("async_rst/sel_conflict", 16'(sel_conflict), 16'h0);
    model_reset();
    #1 erst = 1'b0;
    drive(0, 0, '0, 0, '0, 14'h0100, '0);
    tick("rst_rd8");
    check("rst_rd8/reg_dout", reg_dout, 16'h0000);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            16'($urandom), ($urandom_range(0, 2) == 0), 16'($urandom),
            14'($urandom & $urandom), ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0);
      tick("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
- Parametrised multi-bit register file, generalising the single-bit register slice.
- Sits in the datapath between the PC/address path (left bus) and the internal data path (right bus).
- Keeps the wired-AND, precharged split/joined bus model.
- New behaviour:
  - WIDTH-bit words and configurable register count.
  - Per-pair exchange mapping (EX AF,AF' / EXX style) held in flops.
  - Registered select-conflict flag.

Parameters:
- WIDTH, 16, bits per register and per bus.
- NREGS, 14, number of physical registers.
- NLEFT, 2, registers 0..NLEFT-1 on the left (PC) segment; the rest are on the right segment.
- PAIR_BASE, 6, first physical index of the exchangeable pairs; must be ≥ NLEFT.
- NPAIRS, 4, number of exchangeable pairs: (PAIR_BASE+2k, PAIR_BASE+2k+1), k < NPAIRS; PAIR_BASE+2*NPAIRS ≤ NREGS.
- RESET_VAL, 0, reset contents of every register.

Ports:
- eclk  in  1  system clock; all state updates on rising edge.
- erst  in  1  reset, asynchronous, active-high.
- r_p  in  1  1 = left and right buses joined; 0 = split.
- pc_wr  in  1  left-bus write enable.
- pc_din  in  WIDTH  left-bus write data.
- reg_wr  in  1  right-bus write enable.
- reg_din  in  WIDTH  right-bus write data.
- sel  in  NREGS  logical register select; one-hot per segment in normal use.
- swap  in  NPAIRS  1-cycle pulse; toggles the mapping of pair k.
- pc_dout  out  WIDTH  registered, inverted left-bus value.
- reg_dout  out  WIDTH  registered right-bus value.
- swap_map  out  NPAIRS  current pair mapping state.
- sel_conflict  out  1  registered: more than one register selected in a read-driving segment.

Behaviour:
- Reset (async, immediate on erst rise):
  - pc_dout = all ones; reg_dout = 0; sel_conflict = 0.
  - All registers = RESET_VAL; swap_map = 0.
- Select remap (combinational, from current swap_map):
  - For pair k with swap_map[k]=1, logical sel bits 2k and 2k+1 (offset PAIR_BASE) drive swapped physical registers.
  - All other indices map straight through.
- Bus resolution (combinational, wired-AND, precharged to all ones):
  - Joined (r_p=1): both buses = AND of pc_din (if pc_wr) and reg_din (if reg_wr). If neither write is active, both buses = AND of all selected physical registers.
  - Split (r_p=0):
    - Left bus = pc_din if pc_wr, else AND of selected registers 0..NLEFT-1.
    - Right bus = reg_din if reg_wr, else AND of selected registers NLEFT..NREGS-1.
  - No driver: bus = all ones.
- Writes (rising edge):
  - Left-segment selected registers load the left bus when pc_wr | (r_p & reg_wr).
  - Right-segment selected registers load the right bus when reg_wr | (r_p & pc_wr).
  - Multiple selected registers all load the same value.
- Outputs:
  - pc_dout <= ~left bus; reg_dout <= right bus. One-cycle latency.
- Swap:
  - swap[k]=1 at an edge toggles swap_map[k].
  - The read or write in that same cycle uses the pre-toggle map; the new mapping is effective from the next cycle.
  - A swap held high for N cycles toggles N times.
- sel_conflict: registered each cycle.
  - Set if more than one remapped select bit is active within a segment that is driving its bus from storage (no write active on it).
  - In joined mode the whole array counts as one segment.
  - Informational only: resolution still follows the wired-AND rule.
- Write and swap in the same cycle: data lands in the physical register chosen by the old map.
- erst asserted mid-operation: everything clears asynchronously; the in-flight write is discarded.

Decomposition:
- regfile_pkg holds:
  - default constants (WIDTH, NREGS, NLEFT, PAIR_BASE, NPAIRS);
  - the pure function remap_sel(sel, swap_map);
  - the segment-mask helper.
- One sub-module, regfile_swap_map: owns the swap_map flops and the select remapping. It uses the same async reset.
- Storage, bus resolution and output registers stay in regfile_bank.

Test Plan:
- Reset then idle: after erst pulse, pc_dout=16'hFFFF, reg_dout=16'h0000, swap_map=0, sel_conflict=0. With no sel/no wr, next cycle pc_dout=16'h0000 (inverted precharge) and reg_dout=16'hFFFF.
- Split write/read:
  - Cycle 1: r_p=0, pc_wr=1, pc_din=16'h1234, sel[0]=1, and reg_wr=1, reg_din=16'hA5A5, sel[6]=1.
  - Cycle 2: read sel[0], sel[6].
  - Required: pc_dout=16'hEDCB, reg_dout=16'hA5A5.
- Joined write:
  - r_p=1, pc_wr=1, pc_din=16'h00FF, sel[1]=1, sel[9]=1.
  - Then split reads: reg 1 = 16'h00FF and reg 9 = 16'h00FF.
  - Wired-AND check: with pc_din=16'hF0F0 and reg_din=16'h3C3C both active, both buses = 16'h3030.
- Swap:
  - Write reg 6=16'h1111 and reg 7=16'h2222, then pulse swap[0].
  - Reading logical sel[6] gives reg_dout=16'h2222; a second pulse restores 16'h1111.
  - A write in the swap cycle lands in the old-mapped register.
- Conflict: r_p=0, no writes, sel[6]=sel[8]=1 with contents 16'hFF00 and 16'h0FF0 -> reg_dout=16'h0F00, sel_conflict=1 next cycle.
- Async reset mid-write: assert erst between edges during reg_wr -> outputs clear immediately; a later read returns RESET_VAL; swap_map=0.
